apuracao_votos: RTL and testbench
=================================

Name: apuracao_votos

Overview:
- Parametrised day-phase vote engine for the PoliLobinho game core.
- It walks through every living player in index order and collects one confirmed vote from each player via the one-hot player buttons.
- It tallies the votes per candidate, then scans the tallies and reports the eliminated player, or a tie.
- It sits beside fluxo_dados and is sequenced by unidade_controle. Its button and confirm inputs come from the same conditioning path as the night actions: inverted, converted and edge-detected.

Parameters:
- N_JOGADORES, 5, number of players (2..8).
- W_JOG, 3, width of player index; must be at least ceil(log2(N_JOGADORES)).
- W_CONT, 3, width of each per-candidate vote counter; must hold N_JOGADORES-1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- iniciar  in  1  one-cycle pulse; starts a vote round (accepted only in OCIOSO or FIM).
- vivos  in  N_JOGADORES  alive mask, bit i = player i alive; sampled on the accepted iniciar.
- botoes_jogadores  in  N_JOGADORES  active-high selection, must be one-hot to be a legal vote.
- confirma  in  1  one-cycle pulse; confirms the current selection.
- eleitor_atual  out  W_JOG  index of the player whose vote is awaited.
- aguardando_voto  out  1  high in AGUARDA_VOTO.
- voto_invalido  out  1  one-cycle pulse on a rejected confirma.
- pronto  out  1  high in FIM.
- eliminado  out  W_JOG  index of the player with the most votes (valid when eliminado_valido).
- eliminado_valido  out  1  round produced a unique maximum.
- empate  out  1  two or more candidates share the maximum (maximum > 0).
- db_estado  out  4  state encoding for estado7seg.

Behaviour:
- Reset values: state OCIOSO; all outputs 0; vote counters 0; internal vivos register 0.
- States and encodings: OCIOSO=0, PROXIMO_ELEITOR=1, AGUARDA_VOTO=2, REGISTRA=3, APURA=4, FIM=5.
- OCIOSO/FIM + iniciar:
  - Register vivos and clear all counters, eleitor_atual, eliminado, eliminado_valido and empate.
  - If popcount(vivos) < 2, go to FIM directly: pronto=1, eliminado_valido=0, empate=0 (no quorum).
  - Otherwise go to PROXIMO_ELEITOR with eleitor_atual=0.
- PROXIMO_ELEITOR:
  - If eleitor_atual is alive, go to AGUARDA_VOTO.
  - Else increment eleitor_atual.
  - One cycle per dead player skipped.
  - If eleitor_atual passes N_JOGADORES-1, go to APURA with the scan index at 0.
- AGUARDA_VOTO + confirma: the vote is legal only if all of the following hold:
  - botoes_jogadores is exactly one-hot;
  - the target is alive;
  - the target is not eleitor_atual.
- Legal vote: latch the target index and go to REGISTRA.
- Illegal vote: pulse voto_invalido for exactly the next cycle and stay in AGUARDA_VOTO. Button activity without confirma is ignored.
- REGISTRA:
  - Increment the target's counter. No saturation is needed, because the bound is guaranteed by W_CONT.
  - Increment eleitor_atual and return to PROXIMO_ELEITOR.
  - If eleitor_atual was N_JOGADORES-1, go to APURA instead.
- APURA: scans one candidate per cycle over exactly N_JOGADORES cycles, tracking a running maximum, its index and a tie flag.
  - count > max: update max and index, clear the tie flag.
  - count == max with max > 0: set the tie flag.
  - After the last index, go to FIM.
- Result registered on entry to FIM:
  - Tie flag set: empate=1, eliminado_valido=0.
  - Tie flag clear: empate=0, eliminado_valido=1, eliminado = index of the maximum.
  - Results hold until the next accepted iniciar or reset.
- The block does not modify vivos; the owner of the alive mask applies the elimination.
- iniciar outside OCIOSO/FIM is ignored. confirma outside AGUARDA_VOTO is ignored and produces no voto_invalido.
- Simultaneous iniciar and confirma in FIM: iniciar wins.
- Reset mid-round: return to OCIOSO next edge, with all counters and outputs cleared.

Test Plan:
- N=5, vivos=11111, votes 0→1, 1→2, 2→1, 3→1, 4→0 → FIM with eliminado=1, eliminado_valido=1, empate=0.
- N=5, vivos=11111, votes 0→1, 1→0, 2→0, 3→1, 4→2 → empate=1, eliminado_valido=0.
- vivos=10110: check eleitor_atual visits only 1, 2, 4, and exactly one skip cycle occurs for each of players 0 and 3. Votes 1→2, 2→4, 4→2 → eliminado=2.
- Illegal confirms while eleitor_atual=2 → voto_invalido pulses exactly once each and all counters stay unchanged:
  - buttons=00100 (self-vote);
  - buttons=00011 (not one-hot);
  - target is a dead player.
- vivos=00100 with iniciar → FIM next cycle with pronto=1, eliminado_valido=0, empate=0.
- reset asserted in AGUARDA_VOTO after two registered votes, then a fresh round with votes 0→3, 1→3, 2→3, 3→4, 4→3 → eliminado=3, which proves the counters were cleared.

Source files
------------

// File: rtl/apuracao_votos.sv
// Day-phase vote engine: visits each living player in index order, collects one
// confirmed one-hot vote per voter, tallies per candidate and scans for the result.
module apuracao_votos #(
    parameter int N_JOGADORES = 5,
    parameter int W_JOG       = 3,
    parameter int W_CONT      = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic [N_JOGADORES-1:0] botoes_jogadores,
    input  logic                   confirma,
    output logic [W_JOG-1:0]       eleitor_atual,
    output logic                   aguardando_voto,
    output logic                   voto_invalido,
    output logic                   pronto,
    output logic [W_JOG-1:0]       eliminado,
    output logic                   eliminado_valido,
    output logic                   empate,
    output logic [3:0]             db_estado
);

    typedef enum logic [3:0] {
        OCIOSO          = 4'd0,
        PROXIMO_ELEITOR = 4'd1,
        AGUARDA_VOTO    = 4'd2,
        REGISTRA        = 4'd3,
        APURA           = 4'd4,
        FIM             = 4'd5
    } estado_t;

    localparam logic [W_JOG-1:0]       ULTIMO = W_JOG'(N_JOGADORES - 1);
    localparam logic [N_JOGADORES-1:0] UM     = N_JOGADORES'(1);

    estado_t                   r_estado;
    estado_t                   w_proximo;
    logic [N_JOGADORES-1:0]    r_vivos;
    logic [W_CONT-1:0]         r_contagem [N_JOGADORES];
    logic [W_JOG-1:0]          r_eleitor;
    logic [W_JOG-1:0]          r_alvo;
    logic [W_JOG-1:0]          r_idx_apura;
    logic [W_CONT-1:0]         r_max;
    logic [W_JOG-1:0]          r_idx_max;
    logic                      r_empate_tmp;
    logic [W_JOG-1:0]          r_eliminado;
    logic                      r_eliminado_valido;
    logic                      r_empate;
    logic                      r_voto_invalido;

    logic                      w_inicia;
    logic [3:0]                w_pop;
    logic                      w_quorum;
    logic [W_JOG-1:0]          w_alvo;
    logic                      w_um_quente;
    logic                      w_alvo_vivo;
    logic                      w_auto_voto;
    logic                      w_voto_legal;
    logic                      w_eleitor_vivo;
    logic                      w_ultimo_eleitor;
    logic                      w_ultimo_apura;
    logic [W_CONT-1:0]         w_cand;
    logic [W_CONT-1:0]         w_novo_max;
    logic [W_JOG-1:0]          w_novo_idx;
    logic                      w_novo_empate;

    assign w_inicia         = iniciar && (r_estado == OCIOSO || r_estado == FIM);
    assign w_quorum         = (w_pop >= 4'd2);
    assign w_ultimo_eleitor = (r_eleitor == ULTIMO);
    assign w_ultimo_apura   = (r_idx_apura == ULTIMO);
    assign w_um_quente      = (botoes_jogadores != '0) &&
                              ((botoes_jogadores & (botoes_jogadores - UM)) == '0);
    assign w_alvo_vivo      = ((botoes_jogadores & r_vivos) != '0);
    assign w_voto_legal     = w_um_quente && w_alvo_vivo && !w_auto_voto;

    always_comb begin
        w_pop          = '0;
        w_alvo         = '0;
        w_auto_voto    = 1'b0;
        w_eleitor_vivo = 1'b0;
        w_cand         = '0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            w_pop = w_pop + 4'(vivos[i]);
            if (botoes_jogadores[i]) w_alvo = W_JOG'(i);
            if (W_JOG'(i) == r_eleitor) begin
                w_auto_voto    = botoes_jogadores[i];
                w_eleitor_vivo = r_vivos[i];
            end
            if (W_JOG'(i) == r_idx_apura) w_cand = r_contagem[i];
        end
    end

    // Running maximum: a strictly larger count takes over and clears the tie;
    // an equal non-zero count marks a tie with the current leader.
    always_comb begin
        w_novo_max    = r_max;
        w_novo_idx    = r_idx_max;
        w_novo_empate = r_empate_tmp;
        if (w_cand > r_max) begin
            w_novo_max    = w_cand;
            w_novo_idx    = r_idx_apura;
            w_novo_empate = 1'b0;
        end else if (w_cand == r_max && r_max != '0) begin
            w_novo_empate = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_estado <= OCIOSO;
        else       r_estado <= w_proximo;
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            OCIOSO, FIM: begin
                if (w_inicia) w_proximo = w_quorum ? PROXIMO_ELEITOR : FIM;
            end
            PROXIMO_ELEITOR: begin
                if (w_eleitor_vivo)        w_proximo = AGUARDA_VOTO;
                else if (w_ultimo_eleitor) w_proximo = APURA;
            end
            AGUARDA_VOTO: begin
                if (confirma && w_voto_legal) w_proximo = REGISTRA;
            end
            REGISTRA: begin
                w_proximo = w_ultimo_eleitor ? APURA : PROXIMO_ELEITOR;
            end
            APURA: begin
                if (w_ultimo_apura) w_proximo = FIM;
            end
            default: w_proximo = OCIOSO;
        endcase
    end

    // iniciar and confirma are single-cycle pulses sampled on the rising edge;
    // voto_invalido is a single-cycle pulse in the cycle after a rejected confirma.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vivos            <= '0;
            r_eleitor          <= '0;
            r_alvo             <= '0;
            r_idx_apura        <= '0;
            r_max              <= '0;
            r_idx_max          <= '0;
            r_empate_tmp       <= 1'b0;
            r_eliminado        <= '0;
            r_eliminado_valido <= 1'b0;
            r_empate           <= 1'b0;
            r_voto_invalido    <= 1'b0;
            for (int i = 0; i < N_JOGADORES; i++) r_contagem[i] <= '0;
        end else begin
            r_voto_invalido <= 1'b0;
            case (r_estado)
                OCIOSO, FIM: begin
                    if (w_inicia) begin
                        r_vivos            <= vivos;
                        r_eleitor          <= '0;
                        r_idx_apura        <= '0;
                        r_max              <= '0;
                        r_idx_max          <= '0;
                        r_empate_tmp       <= 1'b0;
                        r_eliminado        <= '0;
                        r_eliminado_valido <= 1'b0;
                        r_empate           <= 1'b0;
                        for (int i = 0; i < N_JOGADORES; i++) r_contagem[i] <= '0;
                    end
                end
                PROXIMO_ELEITOR: begin
                    if (!w_eleitor_vivo && !w_ultimo_eleitor) r_eleitor <= r_eleitor + 1'b1;
                end
                AGUARDA_VOTO: begin
                    if (confirma) begin
                        if (w_voto_legal) r_alvo <= w_alvo;
                        else              r_voto_invalido <= 1'b1;
                    end
                end
                REGISTRA: begin
                    for (int i = 0; i < N_JOGADORES; i++) begin
                        if (W_JOG'(i) == r_alvo) r_contagem[i] <= r_contagem[i] + W_CONT'(1);
                    end
                    if (!w_ultimo_eleitor) r_eleitor <= r_eleitor + 1'b1;
                end
                APURA: begin
                    r_max        <= w_novo_max;
                    r_idx_max    <= w_novo_idx;
                    r_empate_tmp <= w_novo_empate;
                    if (w_ultimo_apura) begin
                        r_idx_apura        <= '0;
                        r_empate           <= w_novo_empate;
                        r_eliminado_valido <= !w_novo_empate;
                        r_eliminado        <= w_novo_idx;
                    end else begin
                        r_idx_apura <= r_idx_apura + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eleitor_atual    = r_eleitor;
    assign aguardando_voto  = (r_estado == AGUARDA_VOTO);
    assign voto_invalido    = r_voto_invalido;
    assign pronto           = (r_estado == FIM);
    assign eliminado        = r_eliminado;
    assign eliminado_valido = r_eliminado_valido;
    assign empate           = r_empate;
    assign db_estado        = r_estado;

endmodule

// File: tb/tb_apuracao_votos.sv
// Bench for apuracao_votos: vote rounds from a table with a result scoreboard,
// plus hand-written sequences for skips, rejected votes, no quorum and reset.
module tb_apuracao_votos;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [4:0] vivos;
    logic [4:0] botoes_jogadores;
    logic       confirma;
    logic [2:0] eleitor_atual;
    logic       aguardando_voto;
    logic       voto_invalido;
    logic       pronto;
    logic [2:0] eliminado;
    logic       eliminado_valido;
    logic       empate;
    logic [3:0] db_estado;

    apuracao_votos #(.N_JOGADORES(5), .W_JOG(3), .W_CONT(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar          (iniciar),
        .vivos            (vivos),
        .botoes_jogadores (botoes_jogadores),
        .confirma         (confirma),
        .eleitor_atual    (eleitor_atual),
        .aguardando_voto  (aguardando_voto),
        .voto_invalido    (voto_invalido),
        .pronto           (pronto),
        .eliminado        (eliminado),
        .eliminado_valido (eliminado_valido),
        .empate           (empate),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  vivos;
        logic [14:0] alvos;   // 3 bits per voter, voter 0 in the low bits
        logic [2:0]  elim;
        logic        valido;
        logic        emp;
    } vec_t;

    vec_t       vecs [6];
    logic [4:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] vivos_ref = '0;
    int         skip_cnt [8];
    logic [7:0] visita = '0;

    function automatic vec_t mk(input logic [4:0] v, input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int el, input int va, input int em);
        vec_t r;
        r.vivos  = v;
        r.alvos  = {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
        r.elim   = 3'(el);
        r.valido = 1'(va);
        r.emp    = 1'(em);
        return r;
    endfunction

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    // Monitor of voter traversal: skip cycles on dead players and voters visited.
    always @(negedge clock) begin
        if (db_estado == 4'd1 && !vivos_ref[eleitor_atual]) skip_cnt[eleitor_atual]++;
        if (aguardando_voto) visita[eleitor_atual] = 1'b1;
    end

    task automatic start_round(input logic [4:0] v, input logic conf);
        vivos_ref = v;
        visita    = '0;
        for (int i = 0; i < 8; i++) skip_cnt[i] = 0;
        iniciar  = 1'b1;
        vivos    = v;
        confirma = conf;
        @(negedge clock);
        iniciar  = 1'b0;
        confirma = 1'b0;
    endtask

    task automatic wait_aguarda();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (aguardando_voto) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("timeout_aguarda", 0, 1);
    endtask

    task automatic cast_vote(input int eleitor, input int alvo);
        wait_aguarda();
        check("eleitor_atual", 32'(eleitor_atual), 32'(eleitor));
        botoes_jogadores = 5'd1 << alvo;
        confirma         = 1'b1;
        @(negedge clock);
        confirma         = 1'b0;
        botoes_jogadores = '0;
        check("no_invalid_on_legal", 32'(voto_invalido), 0);
    endtask

    task automatic bad_vote(input logic [4:0] b, input string nome);
        wait_aguarda();
        botoes_jogadores = b;
        confirma         = 1'b1;
        @(negedge clock);
        confirma         = 1'b0;
        botoes_jogadores = '0;
        check({nome, "_pulse"}, 32'(voto_invalido), 1);
        check({nome, "_still_waiting"}, 32'(aguardando_voto), 1);
        check({nome, "_eleitor"}, 32'(eleitor_atual), 2);
        @(negedge clock);
        check({nome, "_pulse_end"}, 32'(voto_invalido), 0);
    endtask

    task automatic wait_pronto();
        logic       ok;
        logic [4:0] e;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (pronto) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            check("timeout_pronto", 0, 1);
        end else if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("eliminado_valido", 32'(eliminado_valido), 32'(e[1]));
            check("empate", 32'(empate), 32'(e[0]));
            if (e[1]) check("eliminado", 32'(eliminado), 32'(e[4:2]));
        end
    endtask

    task automatic run_vec(input vec_t v);
        start_round(v.vivos, 1'b0);
        exp_q.push_back({v.elim, v.valido, v.emp});
        for (int i = 0; i < 5; i++) begin
            if (v.vivos[i]) cast_vote(i, int'(v.alvos[3*i +: 3]));
        end
        wait_pronto();
    endtask

    initial begin
        reset            = 1'b1;
        iniciar          = 1'b0;
        vivos            = '0;
        botoes_jogadores = '0;
        confirma         = 1'b0;
        for (int i = 0; i < 8; i++) skip_cnt[i] = 0;

        vecs[0] = mk(5'b11111, 1, 2, 1, 1, 0, 1, 1, 0);
        vecs[1] = mk(5'b11111, 1, 0, 0, 1, 2, 0, 0, 1);
        vecs[2] = mk(5'b00111, 1, 0, 1, 0, 0, 1, 1, 0);
        vecs[3] = mk(5'b11000, 0, 0, 0, 4, 3, 0, 0, 1);
        vecs[4] = mk(5'b11111, 4, 4, 4, 4, 0, 4, 1, 0);
        vecs[5] = mk(5'b10001, 4, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_estado", 32'(db_estado), 0);
        check("rst_outputs", 32'({eleitor_atual, aguardando_voto, voto_invalido, pronto,
                                  eliminado, eliminado_valido, empate}), 0);

        // confirma while idle is ignored
        botoes_jogadores = 5'b00010;
        confirma         = 1'b1;
        @(negedge clock);
        confirma         = 1'b0;
        botoes_jogadores = '0;
        check("idle_confirm_no_pulse", 32'(voto_invalido), 0);
        check("idle_confirm_state", 32'(db_estado), 0);

        for (int t = 0; t < 6; t++) run_vec(vecs[t]);

        // results hold in FIM
        repeat (3) @(negedge clock);
        check("hold_pronto", 32'(pronto), 1);
        check("hold_empate", 32'(empate), 1);

        // dead-player skips and rejected votes at voter 2
        start_round(5'b10110, 1'b0);
        exp_q.push_back({3'd2, 1'b1, 1'b0});
        cast_vote(1, 2);
        bad_vote(5'b00100, "self_vote");
        bad_vote(5'b00011, "not_onehot");
        bad_vote(5'b01000, "dead_target");
        botoes_jogadores = 5'b00001;
        @(negedge clock);
        botoes_jogadores = '0;
        check("buttons_no_confirm", 32'(aguardando_voto), 1);
        cast_vote(2, 4);
        cast_vote(4, 2);
        wait_pronto();
        check("skip_player0", skip_cnt[0], 1);
        check("skip_player3", skip_cnt[3], 1);
        check("visited_voters", 32'(visita), 32'(8'b0001_0110));

        // no quorum
        start_round(5'b00100, 1'b0);
        check("noq_pronto", 32'(pronto), 1);
        check("noq_valido", 32'(eliminado_valido), 0);
        check("noq_empate", 32'(empate), 0);

        // iniciar beats confirma in FIM, then reset mid-round
        start_round(5'b11111, 1'b1);
        check("start_wins_state", 32'(db_estado), 1);
        check("start_wins_no_pulse", 32'(voto_invalido), 0);
        cast_vote(0, 4);
        cast_vote(1, 4);
        wait_aguarda();
        iniciar = 1'b1;
        vivos   = 5'b00100;
        @(negedge clock);
        iniciar = 1'b0;
        check("iniciar_ignored_state", 32'(db_estado), 2);
        check("iniciar_ignored_eleitor", 32'(eleitor_atual), 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_estado", 32'(db_estado), 0);
        check("midrst_outputs", 32'({eleitor_atual, aguardando_voto, pronto,
                                     eliminado, eliminado_valido, empate}), 0);
        run_vec(mk(5'b11111, 3, 3, 3, 4, 3, 3, 1, 0));

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
